// File: rtl/uart_mem_transfer_ctrl.sv
// Block transfer sequencer between the UART word encoder/decoder and a single-port sync memory.
// Optional running checksum is enabled by defining UART_MEM_CHECKSUM_EN.
module uart_mem_transfer_ctrl #(
  parameter int WORD_SIZE  = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  loadStart,
  input  logic                  dumpStart,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] lastAddr,
  input  logic                  rxDone,
  input  logic [WORD_SIZE-1:0]  dataToMem,
  input  logic                  txReady,
  output logic                  txStart,
  output logic [WORD_SIZE-1:0]  dataFromMem,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [WORD_SIZE-1:0]  memRdData,
  output logic                  memWrEn,
  output logic [WORD_SIZE-1:0]  memWrData,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_SIZE-1:0]  checksum
);

  typedef enum logic [3:0] {
    IDLE, LD_WAIT, LD_WRITE, DP_READ, DP_LATCH, DP_START, DP_ACK, DP_WAIT, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, last_addr;
  logic                  at_last;
  logic                  start_req;
  logic                  advance;

  assign at_last   = (addr == last_addr);
  assign start_req = (state == IDLE) && (loadStart || dumpStart);
  // Step to the next word only when the current one is finished and more remain.
  assign advance   = !abort && !at_last &&
                     ((state == LD_WRITE) || ((state == DP_WAIT) && txReady));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (loadStart) state_nxt = LD_WAIT;
                else if (dumpStart) state_nxt = DP_READ;
      LD_WAIT:  if (rxDone) state_nxt = LD_WRITE;
      LD_WRITE: state_nxt = at_last ? DONE : LD_WAIT;
      DP_READ:  state_nxt = DP_LATCH;
      DP_LATCH: state_nxt = DP_START;
      DP_START: state_nxt = DP_ACK;
      DP_ACK:   state_nxt = DP_WAIT;
      DP_WAIT:  if (txReady) state_nxt = at_last ? DONE : DP_READ;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      addr      <= '0;
      last_addr <= '0;
    end else if (start_req) begin
      addr      <= '0;
      last_addr <= lastAddr;
    end else if (advance) begin
      addr      <= addr + 1'b1;
    end
  end

  // Word handed to the encoder stays put until the next block read.
  always_ff @(posedge clk) begin
    if (!rstN)                 dataFromMem <= '0;
    else if (state == DP_LATCH) dataFromMem <= memRdData;
  end

`ifdef UART_MEM_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum;

  function automatic logic [WORD_SIZE-1:0] wrap_add(input logic [WORD_SIZE-1:0] a,
                                                    input logic [WORD_SIZE-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstN)                          sum <= '0;
    else if (start_req)                 sum <= '0;
    else if (!abort && state == LD_WRITE) sum <= wrap_add(sum, dataToMem);
    else if (!abort && state == DP_START) sum <= wrap_add(sum, dataFromMem);
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

  assign txStart   = (state == DP_START);
  assign memWrEn   = (state == LD_WRITE);
  assign memWrData = memWrEn ? dataToMem : '0;
  assign memAddr   = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_uart_mem_transfer_ctrl.sv
// Scoreboard bench for uart_mem_transfer_ctrl: randomized loads/dumps against a
// high-level block-transfer model, plus directed start-priority, abort and reset cases.
module tb_uart_mem_transfer_ctrl;
  localparam int WS = 12;
  localparam int AW = 12;
  typedef logic [WS-1:0] word_t;
  typedef struct { logic [AW-1:0] a; word_t d; } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, loadStart, dumpStart, abort, rxDone, txReady;
  logic [AW-1:0] lastAddr;
  word_t         dataToMem, dataFromMem, memRdData, memWrData, checksum;
  logic [AW-1:0] memAddr;
  logic          txStart, memWrEn, busy, done;

  uart_mem_transfer_ctrl #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstN(rstN), .loadStart(loadStart), .dumpStart(dumpStart), .abort(abort),
    .lastAddr(lastAddr), .rxDone(rxDone), .dataToMem(dataToMem), .txReady(txReady),
    .txStart(txStart), .dataFromMem(dataFromMem), .memAddr(memAddr), .memRdData(memRdData),
    .memWrEn(memWrEn), .memWrData(memWrData), .busy(busy), .done(done), .checksum(checksum)
  );

  // Environment memory: one-cycle read latency, plus a bench-side preload port.
  word_t         mem [0:(1<<AW)-1] = '{default: '0};
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  word_t         pre_data = '0;
  always @(posedge clk) begin
    if (memWrEn) mem[memAddr] <= memWrData;
    else if (pre_en) mem[pre_addr] <= pre_data;
    memRdData <= mem[memAddr];
  end

  // Reference model state: expected memory contents.
  word_t ref_mem [0:(1<<AW)-1] = '{default: '0};

  int    tests = 0, fails = 0;
  int    done_cnt = 0, tx_cnt = 0, wr_cnt = 0;
  int    tx_delay = 2;
  int    max_gap = 3;
  wr_t   exp_wr[$];
  word_t exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic word_t exp_ck(input int sum);
`ifdef UART_MEM_CHECKSUM_EN
    return word_t'(sum & ((1 << WS) - 1));
`else
    return '0;
`endif
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes memory or starts a transmit.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (memWrEn) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", memAddr, memWrData);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", memAddr, e.a);
          check("wr_data", memWrData, e.d);
        end
      end
      if (txStart) begin
        tx_cnt++;
        if (exp_tx.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_txStart: data 0x%0h, none expected", dataFromMem);
        end else begin
          word_t e;
          e = exp_tx.pop_front();
          check("tx_data", dataFromMem, e);
        end
      end
      if (done) done_cnt++;
    end
  end

  // Encoder model: drops txReady for tx_delay cycles after each txStart.
  initial begin
    word_t w;
    txReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (txStart === 1'b1) begin
        w = dataFromMem;
        txReady = 1'b0;
        repeat (tx_delay) @(posedge clk);
        #1;
        check("tx_hold", dataFromMem, w);
        txReady = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    if (done_cnt < target) begin
      tests++; fails++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, target);
    end
  endtask

  task automatic pulse_start(input logic ld, input logic dp, input int last);
    @(negedge clk);
    loadStart = ld; dumpStart = dp; lastAddr = AW'(last);
    @(negedge clk);
    loadStart = 1'b0; dumpStart = 1'b0;
    lastAddr = AW'($urandom);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic send_word(input word_t w, input int idx);
    wr_t e;
    e.a = AW'(idx); e.d = w;
    exp_wr.push_back(e);
    dataToMem = w; rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
    check("wr_latency", memWrEn, 1'b1);
    tick(1 + $urandom_range(0, max_gap));
  endtask

  task automatic finish_load(input word_t ws[$]);
    int base = done_cnt;
    int sum = 0;
    for (int i = 0; i < ws.size(); i++) begin
      send_word(ws[i], i);
      sum += ws[i];
      ref_mem[i] = ws[i];
    end
    wait_done(base + 1, 20);
    tick(2);
    check("load_done_once", done_cnt, base + 1);
    check("load_busy_low", busy, 1'b0);
    check("load_checksum", checksum, exp_ck(sum));
  endtask

  task automatic do_dump(input int last);
    int base = done_cnt;
    int tbase = tx_cnt;
    int sum = 0;
    for (int i = 0; i <= last; i++) begin
      exp_tx.push_back(ref_mem[i]);
      sum += ref_mem[i];
    end
    pulse_start(1'b0, 1'b1, last);
    wait_done(base + 1, 40 * (last + 1));
    tick(2);
    check("dump_done_once", done_cnt, base + 1);
    check("dump_tx_count", tx_cnt - tbase, last + 1);
    check("dump_busy_low", busy, 1'b0);
    check("dump_checksum", checksum, exp_ck(sum));
  endtask

  task automatic rand_words(input int n, output word_t ws[$]);
    ws = {};
    for (int i = 0; i < n; i++) ws.push_back(word_t'($urandom));
  endtask

  initial begin
    word_t ws[$];
    int base, tbase, last, sum;
    rstN = 1'b0; loadStart = 1'b0; dumpStart = 1'b0; abort = 1'b0;
    rxDone = 1'b0; dataToMem = '0; lastAddr = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_txStart", txStart, 1'b0);
    check("rst_memWrEn", memWrEn, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_memAddr", memAddr, '0);
    check("rst_memWrData", memWrData, '0);
    check("rst_dataFromMem", dataFromMem, '0);
    check("rst_checksum", checksum, '0);
    rstN = 1'b1;
    tick(2);

    // Directed load of three words.
    pulse_start(1'b1, 1'b0, 2);
    finish_load('{12'h123, 12'h456, 12'hABC});

    // Directed dump of two preloaded words.
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 0; pre_data = 12'h0F0; ref_mem[0] = 12'h0F0;
    @(negedge clk);
    pre_addr = 1; pre_data = 12'h5A5; ref_mem[1] = 12'h5A5;
    @(negedge clk);
    pre_en = 1'b0;
    tx_delay = 3;
    do_dump(1);

    // Simultaneous starts: load must win; a dump request while busy is ignored.
    tbase = tx_cnt;
    pulse_start(1'b1, 1'b1, 0);
    tick(3);
    check("both_start_busy", busy, 1'b1);
    dumpStart = 1'b1;
    @(negedge clk);
    dumpStart = 1'b0;
    rand_words(1, ws);
    finish_load(ws);
    tick(4);
    check("both_start_no_tx", tx_cnt, tbase);

    // Abort during the second DP_WAIT of a four-word dump.
    base = done_cnt; tbase = tx_cnt;
    tx_delay = 6;
    sum = ref_mem[0] + ref_mem[1];
    for (int i = 0; i <= 3; i++) exp_tx.push_back(ref_mem[i]);
    pulse_start(1'b0, 1'b1, 3);
    for (int n = 0; n < 200 && tx_cnt < tbase + 2; n++) begin
      @(negedge clk); #1;
    end
    check("abort_second_tx", tx_cnt, tbase + 2);
    tick(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", busy, 1'b0);
    exp_tx.delete();
    tick(20);
    check("abort_no_more_tx", tx_cnt, tbase + 2);
    check("abort_no_done", done_cnt, base);
    check("abort_checksum_hold", checksum, exp_ck(sum));
    tx_delay = 2;

    // Reset in LD_WAIT after one write, then a fresh load restarts at address 0.
    pulse_start(1'b1, 1'b0, 3);
    rand_words(1, ws);
    send_word(ws[0], 0);
    ref_mem[0] = ws[0];
    check("pre_reset_busy", busy, 1'b1);
    rstN = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_memAddr", memAddr, '0);
    check("mid_rst_memWrEn", memWrEn, 1'b0);
    check("mid_rst_dataFromMem", dataFromMem, '0);
    check("mid_rst_checksum", checksum, '0);
    rstN = 1'b1;
    tick(1);
    pulse_start(1'b1, 1'b0, 1);
    rand_words(2, ws);
    finish_load(ws);

    // Randomized mix of small loads and dumps.
    for (int it = 0; it < 8; it++) begin
      last = $urandom_range(0, 7);
      tx_delay = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        rand_words(last + 1, ws);
        pulse_start(1'b1, 1'b0, last);
        finish_load(ws);
      end else begin
        do_dump(last);
      end
    end

    // Full-memory load: all addresses written once, no wrap back to 0.
    max_gap = 0;
    base = wr_cnt;
    rand_words(1 << AW, ws);
    pulse_start(1'b1, 1'b0, (1 << AW) - 1);
    finish_load(ws);
    tick(5);
    check("full_write_count", wr_cnt - base, 1 << AW);
    check("full_scoreboard_empty", exp_wr.size(), 0);

    // Single-word dump after the full load.
    tx_delay = 1;
    do_dump(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

endmodule
